// File: rtl/cnn_job_sequencer_if.sv
// Single-outstanding Wishbone bundle between the job sequencer and the interconnect.
interface cnn_job_sequencer_if;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [3:0]  o_wb_sel;
    logic [31:0] o_wb_addr;
    logic [31:0] o_wb_data;
    logic [31:0] i_wb_data;
    logic        i_wb_ack;
    logic        i_wb_stall;

    modport master (
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel, o_wb_addr, o_wb_data,
        input  i_wb_data, i_wb_ack, i_wb_stall
    );

    modport slave (
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel, o_wb_addr, o_wb_data,
        output i_wb_data, i_wb_ack, i_wb_stall
    );
endinterface

// File: rtl/cnn_job_sequencer.sv
// Wishbone master that copies an image into the CNN, starts it, polls for
// completion and copies the result map back to memory.
module cnn_job_sequencer #(
    parameter int unsigned IMG_WORDS  = 16,
    parameter int unsigned OUT_WORDS  = 16,
    parameter logic [31:0] CNN_BASE   = 32'h4000_0000,
    parameter logic [31:0] CNN_IN_OFF = 32'h0000_0100,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned POLL_GAP   = 8,
    parameter int unsigned POLL_LIMIT = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [31:0]                src_addr,
    input  logic [31:0]                dst_addr,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    cnn_job_sequencer_if.master        wb
);
    localparam int unsigned MAX_WORDS = (IMG_WORDS > OUT_WORDS) ? IMG_WORDS : OUT_WORDS;
    localparam int unsigned KW = $clog2(MAX_WORDS) + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned PW = $clog2(POLL_LIMIT + 1);
    localparam int unsigned GW = $clog2(POLL_GAP + 1);

    typedef enum logic [3:0] {
        IDLE, RD_IMG, WR_IMG, WR_START, POLL, POLL_WAIT, RD_RES, WR_RES, FINISH
    } state_e;

    state_e        state_q, state_d;
    logic          stb_q, stb_d, we_q, we_d;
    logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [3:0]    sel_q, sel_d;
    logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, buf_q, buf_d;
    logic [31:0]   src_q, src_d, dst_q, dst_d, k_off;
    logic [KW-1:0] k_q, k_d, k_inc;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [PW-1:0] poll_q, poll_d, poll_inc;
    logic [GW-1:0] gap_q, gap_d;
    logic          in_xfer;

    // Stall needs no handling with one request outstanding: only ack ends a hold.
    logic unused_stall;
    assign unused_stall = wb.i_wb_stall;

    assign wb.o_wb_cyc  = stb_q;
    assign wb.o_wb_stb  = stb_q;
    assign wb.o_wb_we   = we_q;
    assign wb.o_wb_sel  = sel_q;
    assign wb.o_wb_addr = addr_q;
    assign wb.o_wb_data = wdata_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

    // Next-state: launch/hold/complete/timeout of bus cycles plus job sequencing.
    always_comb begin
        state_d  = state_q;
        stb_d    = stb_q;
        we_d     = we_q;
        sel_d    = sel_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        buf_d    = buf_q;
        src_d    = src_q;
        dst_d    = dst_q;
        k_d      = k_q;
        tmo_d    = tmo_q;
        poll_d   = poll_q;
        gap_d    = gap_q;
        err_d    = err_q;
        k_inc    = k_q + KW'(1);
        poll_inc = poll_q + PW'(1);
        k_off    = 32'({k_q, 2'b00});
        in_xfer  = (state_q inside {RD_IMG, WR_IMG, WR_START, POLL, RD_RES, WR_RES});

        if (in_xfer) begin
            if (!stb_q) begin
                stb_d   = 1'b1;
                sel_d   = 4'hF;
                tmo_d   = '0;
                we_d    = 1'b0;
                wdata_d = 32'h0;
                case (state_q)
                    RD_IMG:   addr_d = src_q + k_off;
                    WR_IMG:   begin addr_d = CNN_BASE + CNN_IN_OFF + k_off; we_d = 1'b1; wdata_d = buf_q; end
                    WR_START: begin addr_d = CNN_BASE; we_d = 1'b1; wdata_d = 32'h1; end
                    POLL:     addr_d = CNN_BASE;
                    RD_RES:   addr_d = CNN_BASE + 32'd4 + k_off;
                    WR_RES:   begin addr_d = dst_q + k_off; we_d = 1'b1; wdata_d = buf_q; end
                    default:  addr_d = addr_q;
                endcase
            end else if (wb.i_wb_ack) begin
                stb_d   = 1'b0;
                we_d    = 1'b0;
                sel_d   = 4'h0;
                addr_d  = 32'h0;
                wdata_d = 32'h0;
                case (state_q)
                    RD_IMG: begin buf_d = wb.i_wb_data; state_d = WR_IMG; end
                    WR_IMG: begin
                        if (k_inc == KW'(IMG_WORDS)) begin k_d = '0; state_d = WR_START; end
                        else begin k_d = k_inc; state_d = RD_IMG; end
                    end
                    WR_START: begin poll_d = '0; state_d = POLL; end
                    POLL: begin
                        poll_d = poll_inc;
                        if (wb.i_wb_data[1]) begin k_d = '0; state_d = RD_RES; end
                        else if (poll_inc == PW'(POLL_LIMIT)) begin err_d = 1'b1; state_d = FINISH; end
                        else begin gap_d = '0; state_d = POLL_WAIT; end
                    end
                    RD_RES: begin buf_d = wb.i_wb_data; state_d = WR_RES; end
                    WR_RES: begin
                        k_d = k_inc;
                        if (k_inc == KW'(OUT_WORDS)) state_d = FINISH;
                        else state_d = RD_RES;
                    end
                    default: state_d = state_q;
                endcase
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                stb_d   = 1'b0;
                we_d    = 1'b0;
                sel_d   = 4'h0;
                addr_d  = 32'h0;
                wdata_d = 32'h0;
                err_d   = 1'b1;
                state_d = FINISH;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    src_d   = {src_addr[31:2], 2'b00};
                    dst_d   = {dst_addr[31:2], 2'b00};
                    err_d   = 1'b0;
                    k_d     = '0;
                    state_d = RD_IMG;
                end
            end
            POLL_WAIT: begin
                gap_d = gap_q + GW'(1);
                if (gap_q == GW'(POLL_GAP - 1)) state_d = POLL;
            end
            FINISH:  state_d = IDLE;
            default: ;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == FINISH);
    end

    // State and registered outputs; reset drops any bus cycle immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= 4'h0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            buf_q   <= 32'h0;
            src_q   <= 32'h0;
            dst_q   <= 32'h0;
            k_q     <= '0;
            tmo_q   <= '0;
            poll_q  <= '0;
            gap_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            buf_q   <= buf_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            k_q     <= k_d;
            tmo_q   <= tmo_d;
            poll_q  <= poll_d;
            gap_q   <= gap_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_cnn_job_sequencer.sv
// Bench for cnn_job_sequencer: Wishbone slave/CNN model, transaction scoreboard
// and job-level checks of done/err/busy and copied memory contents.
module tb_cnn_job_sequencer;
    localparam logic [31:0] CNN_BASE = 32'h4000_0000;
    localparam logic [31:0] CNN_IN   = 32'h4000_0100;
    localparam int unsigned NW       = 16;
    localparam int unsigned PLIMIT   = 1024;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst, start, busy, done, err;
    logic [31:0] src_addr, dst_addr;

    cnn_job_sequencer_if wb();

    cnn_job_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .busy(busy), .done(done), .err(err), .wb(wb)
    );

    always #5 clk = ~clk;

    // Memory + CNN slave state
    logic [31:0] mem [logic [31:0]];
    logic [31:0] res_val [NW];
    logic [31:0] img_ref [NW];
    int unsigned stall_n = 0, delay_n = 0, done_poll = 0, polls_seen = 0;
    logic        blk_en = 1'b0;
    logic [31:0] blk_addr = 32'h0;
    int unsigned wait_n = 0;
    logic        fire = 1'b0, f_we = 1'b0;
    logic [31:0] f_addr = 32'h0, f_data = 32'h0;

    // Scoreboard and monitor state
    txn_t        exp_q[$];
    int          compared = 0, mismatched = 0;
    int          cyc_n = 0, txn_start = 0, poll_prev_end = -1;
    int unsigned done_cnt = 0, fire_cnt = 0, run_len = 0, last_run = 0, status_reads = 0;
    logic        p_stb = 1'b0, p_ack = 1'b0, p_we = 1'b0;
    logic [31:0] p_addr = 32'h0, p_data = 32'h0;
    bit          exp_err = 1'b0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        logic [31:0] off;
        off = a - CNN_BASE - 32'd4;
        if (a == CNN_BASE)
            return {30'h0, (done_poll != 0) && (polls_seen + 1 >= done_poll), 1'b0};
        if (a >= CNN_BASE + 32'd4 && a < CNN_BASE + 32'd68)
            return res_val[off[5:2]];
        return mem_rd(a);
    endfunction

    // Slave: commit at the clock edge, then present ack/stall/data for the new cycle.
    initial begin
        wb.i_wb_ack = 1'b0; wb.i_wb_stall = 1'b0; wb.i_wb_data = 32'h0;
        forever begin
            @(posedge clk);
            if (fire) begin
                if (f_we) begin
                    if (f_addr == CNN_BASE) polls_seen = 0;
                    else mem[f_addr] = f_data;
                end else if (f_addr == CNN_BASE) begin
                    polls_seen++;
                end
            end
            #1;
            if (wb.o_wb_stb !== 1'b1) wait_n = 0;
            wb.i_wb_stall = (wb.o_wb_stb === 1'b1) && (wait_n < stall_n);
            wb.i_wb_ack   = (wb.o_wb_stb === 1'b1) && (wait_n >= stall_n + delay_n)
                            && !(blk_en && wb.o_wb_we && wb.o_wb_addr == blk_addr);
            wb.i_wb_data  = (wb.o_wb_stb === 1'b1 && !wb.o_wb_we) ? rd_word(wb.o_wb_addr) : 32'h0;
            fire   = wb.i_wb_ack;
            f_we   = wb.o_wb_we;
            f_addr = wb.o_wb_addr;
            f_data = wb.o_wb_data;
            if (wb.o_wb_stb === 1'b1) wait_n++;
        end
    end

    // Monitor: protocol checks and scoreboard pop on every acknowledged cycle.
    initial begin
        txn_t t;
        forever begin
            @(negedge clk);
            if (rst) begin
                p_stb = 1'b0; p_ack = 1'b0; run_len = 0;
            end else begin
                if (done) done_cnt++;
                if (wb.o_wb_stb) run_len++;
                else if (run_len != 0) begin last_run = run_len; run_len = 0; end
                if (wb.o_wb_stb && !p_stb) txn_start = cyc_n;
                if (p_stb && p_ack) begin
                    chk("stb_gap_after_ack", 32'(wb.o_wb_stb), 32'h0);
                end else if (p_stb && wb.o_wb_stb) begin
                    chk("hold_addr", wb.o_wb_addr, p_addr);
                    chk("hold_we", 32'(wb.o_wb_we), 32'(p_we));
                    chk("hold_data", wb.o_wb_data, p_data);
                end
                if (wb.o_wb_stb) begin
                    chk("sel_ones", 32'(wb.o_wb_sel), 32'hF);
                    chk("cyc_with_stb", 32'(wb.o_wb_cyc), 32'h1);
                end
                if (wb.o_wb_stb && wb.i_wb_ack) begin
                    fire_cnt++;
                    if (exp_q.size() == 0) begin
                        compared++; mismatched++;
                        $display("FAIL unexpected_txn: got addr %h we %0d, required none", wb.o_wb_addr, wb.o_wb_we);
                    end else begin
                        t = exp_q.pop_front();
                        chk("txn_addr", wb.o_wb_addr, t.addr);
                        chk("txn_we", 32'(wb.o_wb_we), 32'(t.we));
                        if (t.we) chk("txn_wdata", wb.o_wb_data, t.data);
                    end
                    if (wb.o_wb_addr == CNN_BASE && wb.o_wb_we) poll_prev_end = -1;
                    if (wb.o_wb_addr == CNN_BASE && !wb.o_wb_we) begin
                        status_reads++;
                        if (poll_prev_end >= 0)
                            chk("poll_gap_ge8", 32'((txn_start - poll_prev_end - 1) >= 8), 32'h1);
                        poll_prev_end = cyc_n;
                    end
                end
                p_stb = wb.o_wb_stb; p_ack = wb.i_wb_ack; p_we = wb.o_wb_we;
                p_addr = wb.o_wb_addr; p_data = wb.o_wb_data;
            end
        end
    end

    task automatic push(input logic we, input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        t.we = we; t.addr = a; t.data = d;
        exp_q.push_back(t);
    endtask

    // Reference job: the list of bus cycles the sequencer must complete, in order.
    task automatic build_expected(input logic [31:0] src, input logic [31:0] dst, input int unsigned dpoll);
        logic [31:0] s, d, w;
        int unsigned np;
        s = {src[31:2], 2'b00};
        d = {dst[31:2], 2'b00};
        exp_err = 1'b0;
        for (int k = 0; k < NW; k++) begin
            img_ref[k] = mem_rd(s + 32'(4 * k));
            push(1'b0, s + 32'(4 * k), 32'h0);
            w = CNN_IN + 32'(4 * k);
            if (blk_en && w == blk_addr) begin exp_err = 1'b1; return; end
            push(1'b1, w, img_ref[k]);
        end
        push(1'b1, CNN_BASE, 32'h1);
        np = (dpoll == 0 || dpoll > PLIMIT) ? PLIMIT : dpoll;
        for (int i = 0; i < int'(np); i++) push(1'b0, CNN_BASE, 32'h0);
        if (dpoll == 0 || dpoll > PLIMIT) begin exp_err = 1'b1; return; end
        for (int k = 0; k < NW; k++) begin
            push(1'b0, CNN_BASE + 32'd4 + 32'(4 * k), 32'h0);
            w = d + 32'(4 * k);
            if (blk_en && w == blk_addr) begin exp_err = 1'b1; return; end
            push(1'b1, w, res_val[k]);
        end
    endtask

    task automatic load_img(input logic [31:0] base, input bit fixed);
        for (int k = 0; k < NW; k++)
            mem[base + 32'(4 * k)] = fixed ? (32'h0302_0100 + 32'h0404_0404 * 32'(k)) : $urandom;
    endtask

    int unsigned job_done_base, job_reads_base, job_np;
    logic [31:0] job_dst;

    task automatic begin_job(input logic [31:0] src, input logic [31:0] dst, input int unsigned dpoll,
                             input bit be, input logic [31:0] ba, input int unsigned st,
                             input int unsigned dl, input bit fixed_res);
        blk_en = be; blk_addr = ba; stall_n = st; delay_n = dl; done_poll = dpoll;
        for (int k = 0; k < NW; k++) begin
            res_val[k] = fixed_res ? (32'hC0DE_0000 + 32'(k)) : $urandom;
            mem[{dst[31:2], 2'b00} + 32'(4 * k)] = 32'hDEAD_0000 | 32'(k);
            mem[CNN_IN + 32'(4 * k)] = 32'hBAD0_0000 | 32'(k);
        end
        build_expected(src, dst, dpoll);
        job_np = (dpoll == 0 || dpoll > PLIMIT) ? PLIMIT : dpoll;
        job_dst = {dst[31:2], 2'b00};
        job_done_base = done_cnt;
        job_reads_base = status_reads;
        @(negedge clk);
        start = 1'b1; src_addr = src; dst_addr = dst;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'h1);
        chk("no_stb_first_cycle", 32'(wb.o_wb_stb), 32'h0);
        chk("err_cleared_on_start", 32'(err), 32'h0);
        @(negedge clk);
        chk("stb_two_cycles_after_start", 32'(wb.o_wb_stb), 32'h1);
    endtask

    task automatic finish_job(input bit expect_timeout);
        int n;
        int unsigned f;
        n = 0;
        while (!done && n < 40000) begin @(negedge clk); n++; end
        if (!done) begin
            compared++; mismatched++;
            $display("FAIL job_done_wait: no done within %0d cycles", n);
            return;
        end
        chk("err_at_done", 32'(err), 32'(exp_err));
        chk("busy_at_done", 32'(busy), 32'h1);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'h0);
        chk("busy_falls_with_done", 32'(busy), 32'h0);
        chk("all_txns_seen", 32'(exp_q.size()), 32'h0);
        if (expect_timeout) chk("timeout_stb_cycles", 32'(last_run), 32'd255);
        if (!blk_en) chk("status_read_count", 32'(status_reads - job_reads_base), 32'(job_np));
        if (!exp_err) begin
            for (int k = 0; k < NW; k++) begin
                chk("cnn_input_word", mem_rd(CNN_IN + 32'(4 * k)), img_ref[k]);
                chk("result_word", mem_rd(job_dst + 32'(4 * k)), res_val[k]);
            end
        end
        f = fire_cnt;
        repeat (20) @(negedge clk);
        chk("quiet_after_done", 32'(fire_cnt), 32'(f));
        chk("one_done_pulse", 32'(done_cnt - job_done_base), 32'h1);
    endtask

    initial begin
        int n;
        int unsigned d0;
        logic [31:0] s, d;
        rst = 1'b1; start = 1'b0; src_addr = 32'h0; dst_addr = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_cyc", 32'(wb.o_wb_cyc), 32'h0);
        chk("rst_stb", 32'(wb.o_wb_stb), 32'h0);
        chk("rst_we", 32'(wb.o_wb_we), 32'h0);
        chk("rst_sel", 32'(wb.o_wb_sel), 32'h0);
        chk("rst_addr", wb.o_wb_addr, 32'h0);
        chk("rst_data", wb.o_wb_data, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Zero-wait slave, done on third poll
        load_img(32'h0, 1'b1);
        begin_job(32'h0, 32'h2000, 3, 1'b0, 32'h0, 0, 0, 1'b1);
        finish_job(1'b0);

        // Stalls plus ack delay on every access, same contents expected
        begin_job(32'h0, 32'h3000, 3, 1'b0, 32'h0, 5, 3, 1'b1);
        finish_job(1'b0);

        // Slave never acks the third input-window write
        load_img(32'h0001_0000, 1'b0);
        begin_job(32'h0001_0000, 32'h0002_0000, 3, 1'b1, 32'h4000_0108, 0, 0, 1'b0);
        finish_job(1'b1);

        // CNN never finishes
        load_img(32'h0001_0100, 1'b0);
        begin_job(32'h0001_0100, 32'h0002_0100, 0, 1'b0, 32'h0, 0, 0, 1'b0);
        finish_job(1'b0);

        // Unaligned source and a start pulse while busy
        load_img(32'h0000_1000, 1'b0);
        load_img(32'h0000_5000, 1'b0);
        begin_job(32'h0000_1003, 32'h0000_6002, 2, 1'b0, 32'h0, 0, 1, 1'b0);
        repeat (6) @(negedge clk);
        start = 1'b1; src_addr = 32'h0000_5000; dst_addr = 32'h0000_7000;
        @(negedge clk);
        start = 1'b0;
        finish_job(1'b0);

        // Reset while an input-window write is on the bus
        load_img(32'h0001_1800, 1'b0);
        begin_job(32'h0001_1800, 32'h0002_1800, 2, 1'b0, 32'h0, 2, 1, 1'b0);
        n = 0;
        while (!(wb.o_wb_stb && wb.o_wb_we && wb.o_wb_addr >= CNN_IN && wb.o_wb_addr < CNN_IN + 32'd64)
               && n < 500) begin
            @(negedge clk); n++;
        end
        chk("reached_wr_img", 32'(wb.o_wb_stb && wb.o_wb_we), 32'h1);
        d0 = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_cyc", 32'(wb.o_wb_cyc), 32'h0);
        chk("rst_mid_stb", 32'(wb.o_wb_stb), 32'h0);
        chk("rst_mid_busy", 32'(busy), 32'h0);
        chk("rst_mid_done", 32'(done), 32'h0);
        rst = 1'b0;
        exp_q.delete();
        poll_prev_end = -1;
        repeat (10) @(negedge clk);
        chk("no_done_after_rst", 32'(done_cnt), 32'(d0));
        chk("idle_after_rst", 32'(wb.o_wb_stb), 32'h0);
        begin_job(32'h0001_1800, 32'h0002_1800, 2, 1'b0, 32'h0, 0, 0, 1'b0);
        finish_job(1'b0);

        // Randomized jobs
        for (int j = 0; j < 3; j++) begin
            s = 32'h0003_0000 + (32'($urandom_range(0, 255)) << 6) + 32'($urandom_range(0, 3));
            d = 32'h0005_0000 + (32'($urandom_range(0, 255)) << 6) + 32'($urandom_range(0, 3));
            load_img({s[31:2], 2'b00}, 1'b0);
            begin_job(s, d, $urandom_range(1, 5), 1'b0, 32'h0, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
            finish_job(1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/cnn_job_sequencer.md
# cnn_job_sequencer

Wishbone bus master that runs one complete CNN inference job without host involvement. On a start pulse it copies the packed 8x8 input image from memory into the CNN input window, writes the CNN start bit, polls CNN status until done, then copies the 4x4 result map back to a destination buffer in memory. It sits beside the host master on the wb_interconnect and uses the same single-outstanding Wishbone handshake the host uses.

## Interface
- IMG_WORDS, 16, input words copied, 4 pixels per word.
- OUT_WORDS, 16, result words copied back.
- CNN_BASE, 32'h4000_0000, CNN control/status register; results at CNN_BASE+4+4k.
- CNN_IN_OFF, 32'h0000_0100, input window at CNN_BASE+CNN_IN_OFF+4k.
- TIMEOUT, 255, max cycles waiting for ack per transaction.
- POLL_GAP, 8, idle cycles between status polls.
- POLL_LIMIT, 1024, max status reads before error.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle job request, sampled only in IDLE.
- src_addr  in  32  image base in memory; bits [1:0] ignored (treated as 0).
- dst_addr  in  32  result base in memory; bits [1:0] ignored.
- busy  out  1  high from the cycle after an accepted start until DONE.
- done  out  1  one-cycle pulse at job end (success or error).
- err  out  1  sticky error flag, valid with done; cleared on next accepted start.
- o_wb_cyc, o_wb_stb, o_wb_we  out  1  master strobes.
- o_wb_sel  out  4  always 4'b1111 while stb high.
- o_wb_addr  out  32  transaction address.
- o_wb_data  out  32  write data.
- i_wb_data  in  32  read data.
- i_wb_ack  in  1  slave acknowledge.
- i_wb_stall  in  1  slave stall.

## Operation
- States: IDLE, RD_IMG, WR_IMG, WR_START, POLL, POLL_WAIT, RD_RES, WR_RES, FINISH.
- IDLE: start=1 → latch src/dst (low bits cleared), clear err, k=0, go RD_IMG. start while not IDLE is ignored.
- RD_IMG: read src+4k, capture i_wb_data on ack → WR_IMG.
- WR_IMG: write captured word to CNN_BASE+CNN_IN_OFF+4k; on ack k++; k==IMG_WORDS → WR_START (k=0), else RD_IMG.
- WR_START: write 32'h1 to CNN_BASE → POLL.
- POLL: read CNN_BASE; bit[1]=1 → RD_RES (k=0); else POLL_WAIT. Polls counted; reaching POLL_LIMIT with bit[1]=0 → err=1, FINISH.
- POLL_WAIT: count POLL_GAP idle cycles → POLL.
- RD_RES / WR_RES: read CNN_BASE+4+4k, write to dst+4k; after OUT_WORDS writes → FINISH.
- FINISH: done=1 for one cycle, → IDLE.
- Timeout: ack not seen within TIMEOUT cycles of stb assertion → drop cyc/stb, err=1, FINISH. Remaining copies skipped.
- Counters: k is log2(max(IMG_WORDS,OUT_WORDS))+1 bits; address = base + {k,2'b00}, 32-bit wrap permitted, no check.

## Timing
- Reset: all outputs 0 (cyc, stb, we, sel, addr, data, busy, done, err); state IDLE. rst mid-transaction drops cyc/stb at that edge; no completion of the job, no done pulse.
- Transaction: cyc, stb, we, addr, data, sel asserted together and held stable until the cycle i_wb_ack=1 is sampled; i_wb_stall only extends the wait. Read data captured on the ack edge.
- cyc/stb deassert the cycle after ack; at least one cycle with stb=0 between transactions.
- start→first stb: 2 cycles (start edge → busy; next edge → stb).
- Ack in cycle of stb assertion counts; zero-wait slave yields 2 cycles per transaction.
- Ack while stb low is ignored.
- done asserts in FINISH; busy falls the same cycle done falls.

## Test plan
- Zero-wait slave model, image words 0x03020100..0x3F3E3D3C at src=0x0, CNN done bit set on 3rd poll → 16 writes to 0x4000_0100..0x4000_013C with same data, one write 0x1 to 0x4000_0000, exactly 3 status reads with ≥8 idle cycles between, 16 result copies to dst, done pulse, err=0.
- Slave inserts 5 stall cycles + 3 ack-delay cycles on every access → addr/data/we stable throughout each hold, same final memory contents as scenario 1.
- Slave never acks write to 0x4000_0108 → cyc/stb drop after 255 cycles, err=1, done pulse, no further transactions; next start clears err.
- CNN never sets done → exactly 1024 status reads, then err=1, done; no result reads issued.
- start pulsed during busy, and src_addr=0x1003 → second start ignored; reads begin at 0x1000.
- rst asserted during WR_IMG with stb high → next cycle cyc=stb=busy=0, no done pulse; fresh start runs a full job correctly.
